// File: rtl/seg_display_regs_if.sv
// CPU data-memory bus bundle for the 7-segment display register bank.
// The master drives address, strobes and store data. The slave returns
// the registered load data.
interface seg_display_regs_if;
  logic [31:0] addr;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output mem_write, output mem_read, output wdata, input rdata);
  modport slave  (input addr, input mem_write, input mem_read, input wdata, output rdata);
endinterface

// File: rtl/seg_display_regs.sv
// Register bank between the CPU data bus and the 7-segment display driver.
// CPU stores fill the A0..A2 shadow registers. The shadow is copied
// atomically to the live a0..a2 words on an explicit commit, or after
// TIMEOUT quiet cycles following the last shadow write.
module seg_display_regs #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FC60,
  parameter logic [23:0] TIMEOUT   = 24'd2300000   // must be >= 2
) (
  input  logic                   clk,
  input  logic                   rst,
  seg_display_regs_if.slave      bus,
  output logic [31:0]            a0,
  output logic [31:0]            a1,
  output logic [31:0]            a2,
  output logic [2:0]             cases,
  output logic                   choose,
  output logic                   pending,
  output logic [7:0]             commit_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PEND   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [2:0] OFF_A0     = 3'd0;
  localparam logic [2:0] OFF_A1     = 3'd1;
  localparam logic [2:0] OFF_A2     = 3'd2;
  localparam logic [2:0] OFF_CTRL   = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_MODE   = 3'd5;

  logic [1:0]  state;
  logic [23:0] timer;
  logic [31:0] sh0, sh1, sh2;
  logic        commit_busy;

  logic        hit;
  logic [2:0]  off;
  logic        shadow_wr, ctrl_wr, clear, commit_req, mode_wr;
  logic [31:0] rd_val;

  assign commit_busy = (state == S_COMMIT);
  assign pending     = (state != S_IDLE);

  // Address decode: word-aligned access inside the 32-byte block window.
  assign hit = (bus.addr[31:5] == BASE_ADDR[31:5]) && (bus.addr[1:0] == 2'b00);
  assign off = bus.addr[4:2];

  assign shadow_wr  = hit && bus.mem_write && (off <= OFF_A2);
  assign ctrl_wr    = hit && bus.mem_write && (off == OFF_CTRL);
  assign mode_wr    = hit && bus.mem_write && (off == OFF_MODE);
  assign clear      = ctrl_wr && bus.wdata[1];
  assign commit_req = ctrl_wr && bus.wdata[0] && !bus.wdata[1];

  // Load data mux from the current (pre-write) register values.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    rd_val = '0;
    if (hit && bus.mem_read) begin
      case (off)
        OFF_A0:     rd_val = sh0;
        OFF_A1:     rd_val = sh1;
        OFF_A2:     rd_val = sh2;
        OFF_STATUS: rd_val = {16'b0, commit_cnt, 6'b0, commit_busy, pending};
        OFF_MODE:   rd_val = {28'b0, choose, cases};
        default:    rd_val = '0;
      endcase
    end
  end

  // Registers, commit FSM and quiet-timer; clear overrides the FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: every storage element here is a handful of flops, not a RAM, so all of it is reset.
      state      <= S_IDLE;
      timer      <= '0;
      sh0        <= '0;
      sh1        <= '0;
      sh2        <= '0;
      a0         <= '0;
      a1         <= '0;
      a2         <= '0;
      cases      <= '0;
      choose     <= 1'b0;
      commit_cnt <= '0;
      bus.rdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments make the COMMIT copy see the shadow as it was before a same-cycle write.
      bus.rdata <= rd_val;

      if (mode_wr) begin
        cases  <= bus.wdata[2:0];
        choose <= bus.wdata[3];
      end

      if (clear) begin
        sh0   <= '0;
        sh1   <= '0;
        sh2   <= '0;
        a0    <= '0;
        a1    <= '0;
        a2    <= '0;
        timer <= '0;
        state <= S_IDLE;
      end else begin
        if (shadow_wr) begin
          case (off)
            OFF_A0:  sh0 <= bus.wdata;
            OFF_A1:  sh1 <= bus.wdata;
            default: sh2 <= bus.wdata;
          endcase
        end

        case (state)
          S_IDLE: begin
            if (shadow_wr) begin
              state <= S_PEND;
              timer <= '0;
            end else if (commit_req) begin
              state <= S_COMMIT;
            end
          end
          S_PEND: begin
            if (shadow_wr) begin
              timer <= '0;
            end else if (commit_req || (timer == TIMEOUT - 24'd1)) begin
              state <= S_COMMIT;
              timer <= '0;
            end else begin
              timer <= timer + 24'd1;
            end
          end
          S_COMMIT: begin
            a0 <= sh0;
            a1 <= sh1;
            a2 <= sh2;
            if (commit_cnt != 8'hFF) commit_cnt <= commit_cnt + 8'd1;
            timer <= '0;
            state <= shadow_wr ? S_PEND : S_IDLE;
          end
          default: begin
            state <= S_IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_display_regs.sv
// Self-checking bench for seg_display_regs: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_seg_display_regs;

  localparam logic [31:0] BASE = 32'hFFFF_FC60;
  localparam int          TMO  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a0, a1, a2;
  logic [2:0]  cases;
  logic        choose, pending;
  logic [7:0]  commit_cnt;

  int checks = 0;
  int errors = 0;

  seg_display_regs_if bus ();

  seg_display_regs #(.BASE_ADDR(BASE), .TIMEOUT(24'(TMO))) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .a0         (a0),
    .a1         (a1),
    .a2         (a2),
    .cases      (cases),
    .choose     (choose),
    .pending    (pending),
    .commit_cnt (commit_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_sh [3];
  logic [31:0] m_live [3];
  logic [7:0]  m_cnt;
  logic [2:0]  m_cases;
  logic        m_choose;
  logic        m_waiting;   // uncommitted shadow data, counting quiet cycles
  logic        m_copying;   // copy to live happens at the next edge
  int          m_quiet;
  logic [31:0] m_rdata;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sh[i]   = '0;
      m_live[i] = '0;
    end
    m_cnt = '0; m_cases = '0; m_choose = 1'b0;
    m_waiting = 1'b0; m_copying = 1'b0; m_quiet = 0; m_rdata = '0;
  endtask

  task automatic model_edge(input logic [31:0] ad, input logic we, input logic re, input logic [31:0] wd);
    bit hit;
    int o;
    bit sw, ctl, clr, go;
    hit = (ad[31:5] == BASE[31:5]) && (ad[1:0] == 2'b00);
    o   = int'(ad[4:2]);
    m_rdata = '0;
    if (hit && re) begin
      if (o < 3)       m_rdata = m_sh[o];
      else if (o == 4) m_rdata = {16'b0, m_cnt, 6'b0, m_copying, m_waiting | m_copying};
      else if (o == 5) m_rdata = {28'b0, m_choose, m_cases};
    end
    sw  = hit && we && (o < 3);
    ctl = hit && we && (o == 3);
    clr = ctl && wd[1];
    go  = ctl && wd[0] && !wd[1];
    if (hit && we && o == 5) begin
      m_cases  = wd[2:0];
      m_choose = wd[3];
    end
    if (clr) begin
      for (int i = 0; i < 3; i++) begin
        m_sh[i]   = '0;
        m_live[i] = '0;
      end
      m_waiting = 1'b0; m_copying = 1'b0; m_quiet = 0;
    end else if (m_copying) begin
      for (int i = 0; i < 3; i++) m_live[i] = m_sh[i];
      if (m_cnt < 8'hFF) m_cnt = m_cnt + 8'd1;
      m_copying = 1'b0;
      m_waiting = sw;
      m_quiet   = 0;
      if (sw) m_sh[o] = wd;
    end else if (sw) begin
      m_sh[o]   = wd;
      m_waiting = 1'b1;
      m_quiet   = 0;
    end else if (go) begin
      m_copying = 1'b1;
      m_waiting = 1'b0;
    end else if (m_waiting) begin
      m_quiet++;
      if (m_quiet == TMO) begin
        m_copying = 1'b1;
        m_waiting = 1'b0;
      end
    end
  endtask

  function automatic logic [140:0] obs_vec();
    return {a0, a1, a2, cases, choose, pending, commit_cnt, bus.rdata};
  endfunction

  function automatic logic [140:0] exp_vec();
    return {m_live[0], m_live[1], m_live[2], m_cases, m_choose, m_waiting | m_copying, m_cnt, m_rdata};
  endfunction

  // One bus cycle: drive on the falling edge, step the model at the rising
  // edge, then leave outputs settled 1 time unit after it.
  task automatic drive(input logic [31:0] ad, input logic we, input logic re, input logic [31:0] wd);
    @(negedge clk);
    bus.addr = ad; bus.mem_write = we; bus.mem_read = re; bus.wdata = wd;
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge(ad, we, re, wd);
    #1;
  endtask

  task automatic idle();
    drive(BASE, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [4:0] o, input logic [31:0] d);
    drive(BASE | 32'(o), 1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic [31:0] ad);
    drive(ad, 1'b0, 1'b1, 32'h0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    idle();
    idle();
    checks++;
    if (obs_vec() !== 141'b0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", obs_vec());
    end
    rst = 1'b1;
    idle();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_explicit_commit();
    wr(5'h00, 32'h1234_5678);
    wr(5'h04, 32'hDEAD_BEEF);
    wr(5'h0C, 32'h1);
    checks++;
    if (a0 !== 32'h0 || a1 !== 32'h0 || pending !== 1'b1) begin
      errors++;
      $display("FAIL commit_early: a0=%h a1=%h pending=%b expected 0 0 1", a0, a1, pending);
    end
    idle();
    checks++;
    if (a0 !== 32'h1234_5678 || a1 !== 32'hDEAD_BEEF || commit_cnt !== 8'd1 || pending !== 1'b0) begin
      errors++;
      $display("FAIL commit_live: a0=%h a1=%h cnt=%0d pending=%b expected 12345678 deadbeef 1 0",
               a0, a1, commit_cnt, pending);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL commit_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_auto_commit();
    wr(5'h08, 32'hCAFE_0001);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pending !== 1'b1 || a2 !== 32'h0) begin
        errors++;
        $display("FAIL auto_wait%0d: pending=%b a2=%h expected 1 0", i, pending, a2);
      end
      idle();
    end
    checks++;
    if (pending !== 1'b1 || a2 !== 32'h0) begin
      errors++;
      $display("FAIL auto_wait4: pending=%b a2=%h expected 1 0", pending, a2);
    end
    idle();
    checks++;
    if (a2 !== 32'hCAFE_0001 || pending !== 1'b0) begin
      errors++;
      $display("FAIL auto_fire: a2=%h pending=%b expected cafe0001 0", a2, pending);
    end
    // a rewrite part-way through restarts the quiet count
    wr(5'h08, 32'hCAFE_0002);
    idle();
    idle();
    wr(5'h08, 32'hCAFE_0003);
    for (int i = 0; i < 4; i++) idle();
    checks++;
    if (a2 !== 32'hCAFE_0001 || pending !== 1'b1) begin
      errors++;
      $display("FAIL auto_restart_hold: a2=%h pending=%b expected cafe0001 1", a2, pending);
    end
    idle();
    checks++;
    if (a2 !== 32'hCAFE_0003 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL auto_restart_fire: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_write_during_commit();
    wr(5'h0C, 32'h1);
    wr(5'h00, 32'h0000_0009);
    checks++;
    if (a0 !== 32'h1234_5678 || pending !== 1'b1) begin
      errors++;
      $display("FAIL wdc_commit: a0=%h pending=%b expected 12345678 1", a0, pending);
    end
    for (int i = 0; i < TMO; i++) idle();
    checks++;
    if (a0 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wdc_hold: a0=%h expected 12345678", a0);
    end
    idle();
    checks++;
    if (a0 !== 32'h9 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL wdc_auto: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_clear();
    logic [7:0] cnt_before;
    cnt_before = m_cnt;
    wr(5'h04, 32'h0000_0777);
    wr(5'h0C, 32'h3);
    checks++;
    if (a0 !== 32'h0 || a1 !== 32'h0 || a2 !== 32'h0 || commit_cnt !== cnt_before || pending !== 1'b0) begin
      errors++;
      $display("FAIL clear_live: a0=%h a1=%h a2=%h cnt=%0d pending=%b expected 0 0 0 %0d 0",
               a0, a1, a2, commit_cnt, pending, cnt_before);
    end
    rd(BASE | 32'h4);
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL clear_shadow: rdata=%h expected 0", bus.rdata);
    end
  endtask

  task automatic test_decode();
    wr(5'h14, 32'hFFFF_FFFD);
    checks++;
    if (cases !== 3'b101 || choose !== 1'b1) begin
      errors++;
      $display("FAIL mode_write: cases=%b choose=%b expected 101 1", cases, choose);
    end
    rd(BASE | 32'h14);
    checks++;
    if (bus.rdata !== 32'hD) begin
      errors++;
      $display("FAIL mode_read: rdata=%h expected d", bus.rdata);
    end
    wr(5'h00, 32'h0BAD_F00D);
    rd(BASE | 32'h02);
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_read: rdata=%h expected 0", bus.rdata);
    end
    rd(BASE + 32'h18);
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_read: rdata=%h expected 0", bus.rdata);
    end
    drive(BASE ^ 32'h0000_0100, 1'b1, 1'b0, 32'h5555_5555);
    rd(BASE);
    checks++;
    if (bus.rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL bad_base_write: rdata=%h expected 0badf00d", bus.rdata);
    end
    rd(BASE | 32'h10);
    checks++;
    if (bus.rdata !== m_rdata) begin
      errors++;
      $display("FAIL status_read: rdata=%h expected %h", bus.rdata, m_rdata);
    end
    drive(BASE | 32'h4, 1'b1, 1'b1, 32'hABCD_0123);
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL rw_same_cycle: rdata=%h expected 0", bus.rdata);
    end
    rd(BASE | 32'h4);
    checks++;
    if (bus.rdata !== 32'hABCD_0123) begin
      errors++;
      $display("FAIL rw_new_value: rdata=%h expected abcd0123", bus.rdata);
    end
    idle();
    checks++;
    if (bus.rdata !== 32'h0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL decode_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 257; i++) begin
      wr(5'h0C, 32'h1);
      idle();
    end
    checks++;
    if (commit_cnt !== 8'hFF || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL saturation: cnt=%h got %h expected %h", commit_cnt, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [4:0]  offs [10];
    logic [31:0] ad, wd;
    logic        we, re;
    int          bad;
    offs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C, 5'h02, 5'h09};
    bad = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        idle();
      end else begin
        ad = BASE | 32'(offs[$urandom_range(0, 9)]);
        if ($urandom_range(0, 15) == 0) ad = ad ^ (32'h1 << $urandom_range(5, 31));
        we = 1'($urandom_range(0, 1));
        re = 1'($urandom_range(0, 1));
        wd = $urandom;
        if (ad[4:0] == 5'h0C && $urandom_range(0, 5) != 0) wd[1] = 1'b0;
        drive(ad, we, re, wd);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        bad++;
        if (bad <= 5) $display("FAIL random_cycle%0d: got %h expected %h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.addr = '0; bus.mem_write = 1'b0; bus.mem_read = 1'b0; bus.wdata = '0;
    model_reset();
    test_reset();
    test_explicit_commit();
    test_auto_commit();
    test_write_during_commit();
    test_clear();
    test_decode();
    test_saturation();
    test_random();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
